// File: rtl/dcc_hbridge_drv.sv
// H-bridge gate driver for the DCC track stream: break-before-make dead time,
// overcurrent latch and stuck-line shutdown. Define FAULT_RETRY_EN for timed fault auto-retry.
module dcc_hbridge_drv #(
    parameter int DEAD_TIME    = 8,
    parameter int OC_FILTER    = 4,
    parameter int STUCK_LIMIT  = 600000,
    parameter int RETRY_CYCLES = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic track_in,
    input  logic enable,
    input  logic oc_in,
    input  logic fault_clr,
    output logic hi_a,
    output logic lo_a,
    output logic hi_b,
    output logic lo_b,
    output logic fault,
    output logic stuck
);
    localparam int DW = $clog2(DEAD_TIME) + 1;
    localparam int OW = $clog2(OC_FILTER) + 1;
    localparam int SW = $clog2(STUCK_LIMIT) + 1;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_DEAD    = 3'd1,
        ST_DRIVE_P = 3'd2,
        ST_DRIVE_N = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    logic          trk_meta_r, trk_s, trk_prev_r;
    logic          oc_meta_r, oc_s;
    state_t        state_r, state_nxt_s;
    logic [DW-1:0] dead_cnt_r, dead_cnt_nxt_s;
    logic [OW-1:0] oc_cnt_r, oc_cnt_nxt_s;
    logic [SW-1:0] stk_cnt_r, stk_cnt_nxt_s;
    logic          stuck_nxt_s;
    logic          trk_edge_s, driving_s, oc_trip_s, stuck_hit_s;
    logic [3:0]    gates_nxt_s;

`ifdef FAULT_RETRY_EN
    localparam int RW = $clog2(RETRY_CYCLES) + 1;
    logic [RW-1:0] retry_cnt_r, retry_cnt_nxt_s;
`endif

    // Two-flop synchronizers for the asynchronous inputs, plus track edge history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trk_meta_r <= 1'b0;
            trk_s      <= 1'b0;
            trk_prev_r <= 1'b0;
            oc_meta_r  <= 1'b0;
            oc_s       <= 1'b0;
        end else begin
            trk_meta_r <= track_in;
            trk_s      <= trk_meta_r;
            trk_prev_r <= trk_s;
            oc_meta_r  <= oc_in;
            oc_s       <= oc_meta_r;
        end
    end

    // Next-state, protection counters and gate decode
    always_comb begin
        trk_edge_s  = trk_s ^ trk_prev_r;
        driving_s   = (state_r == ST_DRIVE_P) || (state_r == ST_DRIVE_N);
        oc_trip_s   = (state_r != ST_FAULT) && oc_s && (oc_cnt_r >= OW'(OC_FILTER - 1));
        stuck_hit_s = driving_s && !trk_edge_s && (stk_cnt_r >= SW'(STUCK_LIMIT - 1));
        state_nxt_s = state_r;
        stuck_nxt_s = fault_clr ? 1'b0 : stuck;

        if (oc_trip_s) begin
            state_nxt_s = ST_FAULT;
        end else if (state_r == ST_FAULT) begin
            if (fault_clr) begin
                state_nxt_s = ST_OFF;
            end
`ifdef FAULT_RETRY_EN
            else if (retry_cnt_r >= RW'(RETRY_CYCLES - 1)) begin
                state_nxt_s = ST_OFF;
            end
`endif
            else begin
                state_nxt_s = ST_FAULT;
            end
        end else if (!enable) begin
            state_nxt_s = ST_OFF;
        end else if (stuck_hit_s) begin
            state_nxt_s = ST_OFF;
            stuck_nxt_s = 1'b1;
        end else begin
            case (state_r)
                ST_OFF:     state_nxt_s = (!fault && !stuck) ? ST_DEAD : ST_OFF;
                ST_DEAD: begin
                    if (dead_cnt_r >= DW'(DEAD_TIME - 1)) begin
                        state_nxt_s = trk_s ? ST_DRIVE_P : ST_DRIVE_N;
                    end else begin
                        state_nxt_s = ST_DEAD;
                    end
                end
                ST_DRIVE_P: state_nxt_s = trk_s ? ST_DRIVE_P : ST_DEAD;
                ST_DRIVE_N: state_nxt_s = trk_s ? ST_DEAD : ST_DRIVE_N;
                default:    state_nxt_s = ST_OFF;
            endcase
        end

        dead_cnt_nxt_s = (state_r == ST_DEAD && state_nxt_s == ST_DEAD) ?
                         dead_cnt_r + DW'(1) : DW'(0);
        // Filter is held clear while faulted so a persisting overcurrent re-trips after a full filter window.
        if (state_r == ST_FAULT || !oc_s) begin
            oc_cnt_nxt_s = OW'(0);
        end else if (oc_cnt_r >= OW'(OC_FILTER)) begin
            oc_cnt_nxt_s = oc_cnt_r;
        end else begin
            oc_cnt_nxt_s = oc_cnt_r + OW'(1);
        end
        if (fault_clr || trk_edge_s) begin
            stk_cnt_nxt_s = SW'(0);
        end else if (driving_s && stk_cnt_r < SW'(STUCK_LIMIT)) begin
            stk_cnt_nxt_s = stk_cnt_r + SW'(1);
        end else begin
            stk_cnt_nxt_s = stk_cnt_r;
        end
`ifdef FAULT_RETRY_EN
        retry_cnt_nxt_s = (state_r == ST_FAULT && state_nxt_s == ST_FAULT) ?
                          retry_cnt_r + RW'(1) : RW'(0);
`endif

        // Gate order {hi_a, lo_a, hi_b, lo_b}; only the two cross-diagonal patterns exist.
        case (state_nxt_s)
            ST_DRIVE_P: gates_nxt_s = 4'b1001;
            ST_DRIVE_N: gates_nxt_s = 4'b0110;
            default:    gates_nxt_s = 4'b0000;
        endcase
    end

    // State, counters, flags and registered gate drives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_OFF;
            dead_cnt_r <= DW'(0);
            oc_cnt_r   <= OW'(0);
            stk_cnt_r  <= SW'(0);
            fault      <= 1'b0;
            stuck      <= 1'b0;
            {hi_a, lo_a, hi_b, lo_b} <= 4'b0000;
        end else begin
            state_r    <= state_nxt_s;
            dead_cnt_r <= dead_cnt_nxt_s;
            oc_cnt_r   <= oc_cnt_nxt_s;
            stk_cnt_r  <= stk_cnt_nxt_s;
            fault      <= (state_nxt_s == ST_FAULT);
            stuck      <= stuck_nxt_s;
            {hi_a, lo_a, hi_b, lo_b} <= gates_nxt_s;
        end
    end

`ifdef FAULT_RETRY_EN
    // Fault hold-off timer, restarted on every entry into the fault state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_cnt_r <= RW'(0);
        end else begin
            retry_cnt_r <= retry_cnt_nxt_s;
        end
    end
`endif

endmodule
